lcd_frame_gen: RTL and testbench

Parametrised character-frame generator for the HD44780-style LCD path. It replaces per-position combinational character lookup with a snapshot-and-stream engine. On request, or automatically when the displayed data changes, it captures CPU debug fields and streams ROWS*COLS ASCII characters to the LCD driver over a valid/ready handshake, tagged with row and column. It sits between the CPU debug taps (instr, PC, register file, data memory) and the LCD controller.

---
 rtl/lcd_pkg.sv | 63 ++++++
 rtl/lcd_char_rom.sv | 117 +++++++++++
 rtl/lcd_frame_gen.sv | 203 ++++++++++++++++++++
 tb/tb_lcd_frame_gen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, types and helpers for the LCD frame path.
// Ports: none (package). ASCII codes, display modes, FSM states, mnemonics.
package lcd_pkg;

   localparam logic [7:0] ASC_SPACE  = 8'h20;
   localparam logic [7:0] ASC_DOLLAR = 8'h24;
   localparam logic [7:0] ASC_COLON  = 8'h3A;
   localparam logic [7:0] ASC_EQUAL  = 8'h3D;

   typedef enum logic [1:0] {
      MODE_INSTR = 2'd0,
      MODE_REG   = 2'd1,
      MODE_DMEM  = 2'd2,
      MODE_TEXT  = 2'd3
   } lcd_mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } lcd_state_e;

   // Fixed labels, left-justified in 8 bytes (first char in the top byte).
   localparam logic [63:0] STR_PC       = {"PC", ASC_EQUAL, {5{ASC_SPACE}}};
   localparam logic [63:0] STR_REG      = {"Reg", {5{ASC_SPACE}}};
   localparam logic [63:0] STR_D        = {"D", {7{ASC_SPACE}}};
   localparam logic [63:0] STR_DMEM     = {"DMEM", {4{ASC_SPACE}}};
   localparam logic [63:0] STR_DEFAULT  = {"Default", ASC_SPACE};
   localparam logic [63:0] STR_DEFAULT3 = "Default3";

   // Four-character space-padded mnemonic; all spaces means unknown opcode.
   function automatic logic [31:0] mnem_str(input logic [3:0] op);
      logic [31:0] s;
      unique case (op)
         4'h0:    s = "And ";
         4'h1:    s = "or  ";
         4'h2:    s = "Add ";
         4'h3:    s = "Addi";
         4'h6:    s = "Sub ";
         4'h7:    s = "SLT ";
         4'h8:    s = "LW  ";
         4'hA:    s = "SW  ";
         4'hE:    s = "BNE ";
         4'hF:    s = "Jump";
         default: s = {4{ASC_SPACE}};
      endcase
      return s;
   endfunction

   function automatic logic mnem_valid(input logic [3:0] op);
      return mnem_str(op) != {4{ASC_SPACE}};
   endfunction

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'hA) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Character k (0..7) of a left-justified 8-byte label.
   function automatic logic [7:0] str_char(input logic [63:0] s,
                                           input int k);
      return 8'(s >> (56 - 8 * k));
   endfunction

endpackage

// File: rtl/lcd_char_rom.sv
// lcd_char_rom: combinational map of (fields, mode, row, col) to ASCII.
// Ports: mode + debug fields in, row/col index in, ch (ASCII) out.
module lcd_char_rom
   import lcd_pkg::*;
#(
   parameter int COLS      = 16,
   parameter int ROWS      = 2,
   parameter int PC_W      = 16,
   parameter int WORD_W    = 32,
   parameter int REG_IDX_W = 4,
   localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int COL_W    = $clog2(COLS)
) (
   input  lcd_mode_e              mode,
   input  logic [15:0]            instr,
   input  logic [PC_W-1:0]        pc,
   input  logic [REG_IDX_W-1:0]   reg_idx,
   input  logic [WORD_W-1:0]      reg_data0,
   input  logic [WORD_W-1:0]      reg_data1,
   input  logic [PC_W-1:0]        dmem_addr,
   input  logic [WORD_W-1:0]      dmem_data,
   input  logic [ROW_W-1:0]       row,
   input  logic [COL_W-1:0]       col,
   output logic [7:0]             ch
);

   localparam int PC_N   = PC_W / 4;
   localparam int WORD_N = WORD_W / 4;
   localparam int IDX_N  = REG_IDX_W / 4;

   localparam int PC_END    = 3 + PC_N;
   localparam int REG_COLON = 3 + IDX_N;
   localparam int REG_END   = REG_COLON + 1 + WORD_N;
   localparam int D_COLON   = 1 + PC_N;
   localparam int D_END     = D_COLON + 1 + WORD_N;

   if (PC_END > COLS || REG_END > COLS || D_END > COLS || COLS < 13)
   begin : g_bad_layout
      $error("lcd_char_rom: field layout exceeds COLS");
   end

   if ((PC_W % 4) != 0 || (WORD_W % 4) != 0 || (REG_IDX_W % 4) != 0)
   begin : g_bad_width
      $error("lcd_char_rom: field widths must be nibble multiples");
   end

   logic [3:0]           op;
   logic [REG_IDX_W-1:0] idx;
   logic [WORD_W-1:0]    word;
   int                   c;

   assign op = instr[15:12];

   always_comb begin
      ch   = ASC_SPACE;
      c    = int'(col);
      // Row 1 of the register view shows the next index, wrapping.
      idx  = (row == '0) ? reg_idx : REG_IDX_W'(reg_idx + 1'b1);
      word = (row == '0) ? reg_data0 : reg_data1;
      if (int'(row) < 2) begin
         unique case (mode)
            MODE_INSTR: begin
               if (row == '0) begin
                  if (mnem_valid(op)) begin
                     if (c < 4)
                        ch = str_char({mnem_str(op), {4{ASC_SPACE}}}, c);
                     else if (c == 5 || c == 8 || c == 11)
                        ch = ASC_DOLLAR;
                     else if (c == 6)
                        ch = hex_ascii(instr[11:8]);
                     else if (c == 9)
                        ch = hex_ascii(instr[7:4]);
                     else if (c == 12)
                        ch = hex_ascii(instr[3:0]);
                  end else if (c < 7) begin
                     ch = str_char(STR_DEFAULT, c);
                  end
               end else begin
                  if (c < 3)
                     ch = str_char(STR_PC, c);
                  else if (c < PC_END)
                     ch = hex_ascii(4'(pc >> (4 * (PC_END - 1 - c))));
               end
            end
            MODE_REG: begin
               if (c < 3)
                  ch = str_char(STR_REG, c);
               else if (c < REG_COLON)
                  ch = hex_ascii(4'(idx >> (4 * (REG_COLON - 1 - c))));
               else if (c == REG_COLON)
                  ch = ASC_COLON;
               else if (c < REG_END)
                  ch = hex_ascii(4'(word >> (4 * (REG_END - 1 - c))));
            end
            MODE_DMEM: begin
               if (row == '0) begin
                  if (c < 1)
                     ch = str_char(STR_D, c);
                  else if (c < D_COLON)
                     ch = hex_ascii(4'(dmem_addr >> (4 * (D_COLON - 1 - c))));
                  else if (c == D_COLON)
                     ch = ASC_COLON;
                  else if (c < D_END)
                     ch = hex_ascii(4'(dmem_data >> (4 * (D_END - 1 - c))));
               end else if (c < 4) begin
                  ch = str_char(STR_DMEM, c);
               end
            end
            MODE_TEXT: begin
               if (row == '0 && c < 8)
                  ch = str_char(STR_DEFAULT3, c);
            end
         endcase
      end
   end

endmodule

// File: rtl/lcd_frame_gen.sv
// lcd_frame_gen: snapshot-and-stream LCD character frame generator.
// Ports: clk/rst, mode + CPU debug taps, frame_req/auto_en in;
//        ch_data/ch_row/ch_col/ch_valid out with ch_ready in;
//        busy and frame_done status out.
module lcd_frame_gen
   import lcd_pkg::*;
#(
   parameter int COLS      = 16,
   parameter int ROWS      = 2,
   parameter int PC_W      = 16,
   parameter int WORD_W    = 32,
   parameter int REG_IDX_W = 4,
   localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int COL_W    = $clog2(COLS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           mode,
   input  logic [15:0]          instr,
   input  logic [PC_W-1:0]      pc,
   input  logic [REG_IDX_W-1:0] reg_idx,
   input  logic [WORD_W-1:0]    reg_data0,
   input  logic [WORD_W-1:0]    reg_data1,
   input  logic [PC_W-1:0]      dmem_addr,
   input  logic [WORD_W-1:0]    dmem_data,
   input  logic                 frame_req,
   input  logic                 auto_en,
   output logic [7:0]           ch_data,
   output logic [ROW_W-1:0]     ch_row,
   output logic [COL_W-1:0]     ch_col,
   output logic                 ch_valid,
   input  logic                 ch_ready,
   output logic                 busy,
   output logic                 frame_done
);

   typedef struct packed {
      lcd_mode_e            mode;
      logic [15:0]          instr;
      logic [PC_W-1:0]      pc;
      logic [REG_IDX_W-1:0] reg_idx;
      logic [WORD_W-1:0]    rd0;
      logic [WORD_W-1:0]    rd1;
      logic [PC_W-1:0]      daddr;
      logic [WORD_W-1:0]    ddata;
   } snap_t;

   lcd_state_e       state_q, state_d;
   snap_t            live, src, snap_q, snap_d;
   logic             snap_valid_q, snap_valid_d;
   logic             pending_q, pending_d;
   logic             busy_q, busy_d;
   logic             ch_valid_q, ch_valid_d;
   logic             frame_done_q, frame_done_d;
   logic [7:0]       ch_data_q, ch_data_d;
   logic [ROW_W-1:0] ch_row_q, ch_row_d;
   logic [COL_W-1:0] ch_col_q, ch_col_d;

   logic             src_live;
   logic             col_last, row_last;
   logic [ROW_W-1:0] nxt_row, rom_row;
   logic [COL_W-1:0] nxt_col, rom_col;
   logic [7:0]       rom_ch;
   logic             field_diff, dirty, start;

   assign live = '{
      mode:    lcd_mode_e'(mode),
      instr:   instr,
      pc:      pc,
      reg_idx: reg_idx,
      rd0:     reg_data0,
      rd1:     reg_data1,
      daddr:   dmem_addr,
      ddata:   dmem_data
   };

   // In IDLE the ROM looks at live inputs so char(0,0) can be loaded on
   // the same edge that captures them; while emitting it reads the snapshot.
   assign src_live = (state_q == ST_IDLE);
   assign src      = src_live ? live : snap_q;

   assign col_last = (ch_col_q == COL_W'(COLS - 1));
   assign row_last = (ch_row_q == ROW_W'(ROWS - 1));
   assign nxt_col  = col_last ? '0 : ch_col_q + 1'b1;
   assign nxt_row  = col_last ? ch_row_q + 1'b1 : ch_row_q;
   assign rom_row  = src_live ? '0 : nxt_row;
   assign rom_col  = src_live ? '0 : nxt_col;

   lcd_char_rom #(
      .COLS      (COLS),
      .ROWS      (ROWS),
      .PC_W      (PC_W),
      .WORD_W    (WORD_W),
      .REG_IDX_W (REG_IDX_W)
   ) u_rom (
      .mode      (src.mode),
      .instr     (src.instr),
      .pc        (src.pc),
      .reg_idx   (src.reg_idx),
      .reg_data0 (src.rd0),
      .reg_data1 (src.rd1),
      .dmem_addr (src.daddr),
      .dmem_data (src.ddata),
      .row       (rom_row),
      .col       (rom_col),
      .ch        (rom_ch)
   );

   // Only the fields the live mode actually shows count as a change.
   always_comb begin
      field_diff = 1'b0;
      unique case (live.mode)
         MODE_INSTR: field_diff = (live.instr != snap_q.instr) ||
                                  (live.pc != snap_q.pc);
         MODE_REG:   field_diff = (live.reg_idx != snap_q.reg_idx) ||
                                  (live.rd0 != snap_q.rd0) ||
                                  (live.rd1 != snap_q.rd1);
         MODE_DMEM:  field_diff = (live.daddr != snap_q.daddr) ||
                                  (live.ddata != snap_q.ddata);
         MODE_TEXT:  field_diff = 1'b0;
      endcase
   end

   assign dirty = !snap_valid_q || (live.mode != snap_q.mode) || field_diff;
   assign start = frame_req || pending_q || (auto_en && dirty);

   always_comb begin
      state_d      = state_q;
      snap_d       = snap_q;
      snap_valid_d = snap_valid_q;
      pending_d    = pending_q;
      busy_d       = busy_q;
      ch_valid_d   = ch_valid_q;
      ch_data_d    = ch_data_q;
      ch_row_d     = ch_row_q;
      ch_col_d     = ch_col_q;
      frame_done_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_EMIT;
               snap_d       = live;
               snap_valid_d = 1'b1;
               pending_d    = 1'b0;
               busy_d       = 1'b1;
               ch_valid_d   = 1'b1;
               ch_row_d     = '0;
               ch_col_d     = '0;
               ch_data_d    = rom_ch;
            end
         end
         ST_EMIT: begin
            pending_d = pending_q | frame_req;
            if (ch_ready) begin
               if (row_last && col_last) begin
                  state_d      = ST_IDLE;
                  ch_valid_d   = 1'b0;
                  busy_d       = 1'b0;
                  frame_done_d = 1'b1;
               end else begin
                  ch_row_d  = nxt_row;
                  ch_col_d  = nxt_col;
                  ch_data_d = rom_ch;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         snap_q       <= '0;
         snap_valid_q <= 1'b0;
         pending_q    <= 1'b0;
         busy_q       <= 1'b0;
         ch_valid_q   <= 1'b0;
         ch_data_q    <= ASC_SPACE;
         ch_row_q     <= '0;
         ch_col_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         snap_q       <= snap_d;
         snap_valid_q <= snap_valid_d;
         pending_q    <= pending_d;
         busy_q       <= busy_d;
         ch_valid_q   <= ch_valid_d;
         ch_data_q    <= ch_data_d;
         ch_row_q     <= ch_row_d;
         ch_col_q     <= ch_col_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign ch_data    = ch_data_q;
   assign ch_row     = ch_row_q;
   assign ch_col     = ch_col_q;
   assign ch_valid   = ch_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_gen.sv
// tb_lcd_frame_gen: scoreboard bench for lcd_frame_gen (4-row build).
// Expected frames are hand-written strings queued ahead of each frame.
module tb_lcd_frame_gen;

   localparam int COLS  = 16;
   localparam int ROWS  = 4;
   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);
   localparam int NCH   = ROWS * COLS;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        mode;
   logic [15:0]       instr;
   logic [15:0]       pc;
   logic [3:0]        reg_idx;
   logic [31:0]       reg_data0, reg_data1;
   logic [15:0]       dmem_addr;
   logic [31:0]       dmem_data;
   logic              frame_req, auto_en, ch_ready;
   logic [7:0]        ch_data;
   logic [ROW_W-1:0]  ch_row;
   logic [COL_W-1:0]  ch_col;
   logic              ch_valid, busy, frame_done;

   always #5 clk = ~clk;

   lcd_frame_gen #(
      .COLS(COLS), .ROWS(ROWS), .PC_W(16), .WORD_W(32), .REG_IDX_W(4)
   ) u_dut (
      .clk(clk), .rst(rst), .mode(mode), .instr(instr), .pc(pc),
      .reg_idx(reg_idx), .reg_data0(reg_data0), .reg_data1(reg_data1),
      .dmem_addr(dmem_addr), .dmem_data(dmem_data),
      .frame_req(frame_req), .auto_en(auto_en),
      .ch_data(ch_data), .ch_row(ch_row), .ch_col(ch_col),
      .ch_valid(ch_valid), .ch_ready(ch_ready),
      .busy(busy), .frame_done(frame_done)
   );

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
      logic [7:0]       data;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   n_done = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame(input string r0, input string r1);
      exp_t e;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            e.row  = ROW_W'(r);
            e.col  = COL_W'(c);
            e.data = 8'h20;
            if (r == 0 && c < r0.len()) e.data = r0[c];
            else if (r == 1 && c < r1.len()) e.data = r1[c];
            sb.push_back(e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_req();
      frame_req = 1'b1;
      tick();
      frame_req = 1'b0;
   endtask

   task automatic wait_done(input string name, output int cyc);
      cyc = 0;
      while (!frame_done && cyc < 500) begin
         tick();
         cyc++;
      end
      check({name, "_frame_done"}, 32'(frame_done), 32'd1);
   endtask

   task automatic wait_index(input string name, input int r, input int c);
      int k = 0;
      while (!(ch_valid && int'(ch_row) == r && int'(ch_col) == c) &&
             k < 200) begin
         tick();
         k++;
      end
      check({name, "_reach_col"}, 32'(ch_col), 32'(c));
   endtask

   task automatic run_frame(input string name, input string r0,
                            input string r1);
      int cyc;
      push_frame(r0, r1);
      pulse_req();
      check({name, "_first_valid"}, 32'(ch_valid), 32'd1);
      wait_done(name, cyc);
      tick();
   endtask

   // Monitor: pops one expected character per accepted transfer and
   // checks that a stalled character stays put until accepted.
   initial begin
      exp_t             e;
      logic             stall_prev;
      logic [7:0]       h_data;
      logic [ROW_W-1:0] h_row;
      logic [COL_W-1:0] h_col;
      stall_prev = 1'b0;
      h_data = '0;
      h_row = '0;
      h_col = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("hold_valid", 32'(ch_valid), 32'd1);
               check("hold_char", 32'({ch_row, ch_col, ch_data}),
                     32'({h_row, h_col, h_data}));
            end
            if (ch_valid && ch_ready) begin
               tests++;
               if (sb.size() == 0) begin
                  fails++;
                  $display("FAIL char: got r%0d c%0d %02h, expected none",
                           ch_row, ch_col, ch_data);
               end else begin
                  e = sb.pop_front();
                  if ({ch_row, ch_col, ch_data} !== {e.row, e.col, e.data})
                  begin
                     fails++;
                     $display("FAIL char: got r%0d c%0d %02h, expected r%0d c%0d %02h",
                              ch_row, ch_col, ch_data, e.row, e.col, e.data);
                  end
               end
            end
            if (frame_done) n_done++;
            stall_prev = ch_valid && !ch_ready;
            h_data = ch_data;
            h_row  = ch_row;
            h_col  = ch_col;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv, cyc, d0;
      rst = 1'b1;
      mode = 2'd0;
      instr = 16'h2123;
      pc = 16'h00A4;
      reg_idx = 4'h0;
      reg_data0 = 32'h0;
      reg_data1 = 32'h0;
      dmem_addr = 16'h0;
      dmem_data = 32'h0;
      frame_req = 1'b0;
      auto_en = 1'b0;
      ch_ready = 1'b1;
      tick();
      tick();
      check("rst_valid", 32'(ch_valid), 32'd0);
      check("rst_data", 32'(ch_data), 32'h20);
      check("rst_row_col", 32'({ch_row, ch_col}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      rst = 1'b0;
      repeat (3) tick();
      check("idle_no_auto", 32'(ch_valid), 32'd0);

      // Mode 0 frame: latency, length, frame_done timing.
      push_frame("Add  $1 $2 $3", "PC=00A4");
      pulse_req();
      check("t1_latency", 32'(ch_valid), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      nv = 0;
      cyc = 1;
      while (!frame_done && cyc < 500) begin
         if (ch_valid) nv++;
         tick();
         cyc++;
      end
      check("t1_valid_cycles", 32'(nv), 32'(NCH));
      check("t1_done_cycle", 32'(cyc), 32'(NCH + 1));
      check("t1_busy_at_done", 32'(busy), 32'd0);
      check("t1_valid_at_done", 32'(ch_valid), 32'd0);
      tick();
      check("t1_done_pulse", 32'(frame_done), 32'd0);

      // Back-pressure at index 5.
      push_frame("Add  $1 $2 $3", "PC=00A4");
      pulse_req();
      wait_index("t2", 0, 5);
      ch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_stall_col", 32'(ch_col), 32'd5);
         check("t2_stall_data", 32'(ch_data), 32'h24);
      end
      ch_ready = 1'b1;
      wait_done("t2", cyc);
      tick();

      // Register view with index wrap.
      mode = 2'd1;
      reg_idx = 4'hF;
      reg_data0 = 32'hDEADBEEF;
      reg_data1 = 32'h1;
      run_frame("t3", "RegF:DEADBEEF", "Reg0:00000001");

      // Other layouts.
      mode = 2'd0;
      instr = 16'h4123;
      run_frame("t6_default", "Default", "PC=00A4");
      instr = 16'hF0AB;
      run_frame("t6_jump", "Jump $0 $A $B", "PC=00A4");
      instr = 16'h1456;
      pc = 16'h1F0C;
      run_frame("t6_or", "or   $4 $5 $6", "PC=1F0C");
      mode = 2'd2;
      dmem_addr = 16'h0010;
      dmem_data = 32'h12345678;
      run_frame("t6_dmem", "D0010:12345678", "DMEM");
      mode = 2'd3;
      run_frame("t6_text", "Default3", "");

      // Reset in the middle of a frame.
      mode = 2'd0;
      instr = 16'h2123;
      pc = 16'h00A4;
      push_frame("Add  $1 $2 $3", "PC=00A4");
      pulse_req();
      wait_index("t5", 0, 10);
      d0 = n_done;
      rst = 1'b1;
      #1;
      check("t5_valid_low", 32'(ch_valid), 32'd0);
      check("t5_busy_low", 32'(busy), 32'd0);
      sb.delete();
      tick();
      tick();
      rst = 1'b0;
      repeat (5) tick();
      check("t5_no_done", 32'(n_done - d0), 32'd0);
      push_frame("Add  $1 $2 $3", "PC=00A4");
      pulse_req();
      check("t5_restart_rc", 32'({ch_row, ch_col}), 32'd0);
      wait_done("t5", cyc);
      tick();

      // Automatic refresh and request collapsing.
      rst = 1'b1;
      auto_en = 1'b1;
      tick();
      d0 = n_done;
      push_frame("Add  $1 $2 $3", "PC=00A4");
      rst = 1'b0;
      wait_done("t4_auto", cyc);
      repeat (20) tick();
      check("t4_one_auto", 32'(n_done - d0), 32'd1);
      check("t4_no_refresh", 32'(busy), 32'd0);
      pc = 16'h00A8;
      push_frame("Add  $1 $2 $3", "PC=00A8");
      wait_done("t4_pc", cyc);
      repeat (20) tick();
      check("t4_pc_frame", 32'(n_done - d0), 32'd2);
      push_frame("Add  $1 $2 $3", "PC=00A8");
      push_frame("Add  $1 $2 $3", "PC=00A8");
      pulse_req();
      repeat (5) tick();
      pulse_req();
      repeat (3) tick();
      pulse_req();
      wait_done("t4_req", cyc);
      tick();
      check("t4_pending_start", 32'(ch_valid), 32'd1);
      wait_done("t4_pend", cyc);
      repeat (20) tick();
      check("t4_collapse", 32'(n_done - d0), 32'd4);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
